// File: rtl/vec_serializer.sv
// Serialises one vector of up to NUM_ELEMS elements into single-element beats,
// flagging the final element of each vector with send_last.
module vec_serializer #(
    parameter int ELEM_W    = 8,
    parameter int NUM_ELEMS = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [ELEM_W*NUM_ELEMS-1:0]       recv_msg,
    input  logic [$clog2(NUM_ELEMS):0]        recv_len,
    input  logic                              recv_val,
    output logic                              recv_rdy,
    output logic [ELEM_W-1:0]                 send_msg,
    output logic                              send_last,
    output logic                              send_val,
    input  logic                              send_rdy,
    output logic                              dbg_state_o
);

    localparam int IW = $clog2(NUM_ELEMS) + 1;
    localparam logic [IW-1:0] MAX_LEN = IW'(NUM_ELEMS);

    // Handshake: a beat moves on a posedge where val && rdy; no val ever
    // depends combinationally on the matching rdy, and send_val, once raised,
    // stays high with a stable payload until the beat is taken.
    typedef enum logic {IDLE, SEND} state_t;

    state_t                                state_q, state_d;
    logic [IW-1:0]                         idx_q, idx_d;
    logic [IW-1:0]                         len_q, len_d;
    logic [NUM_ELEMS-1:0][ELEM_W-1:0]      buf_q, buf_d;
    logic [IW-1:0]                         len_clamped;
    logic                                  is_last;

    assign dbg_state_o = (state_q == SEND);
    assign len_clamped = (recv_len > MAX_LEN) ? MAX_LEN : recv_len;
    assign is_last     = (idx_q == len_q - IW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        buf_d     = buf_q;
        recv_rdy  = 1'b0;
        send_val  = 1'b0;
        send_last = 1'b0;
        send_msg  = '0;
        // Outputs are silenced for the whole time reset is held.
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    recv_rdy = 1'b1;
                    if (recv_val) begin
                        buf_d = recv_msg;
                        len_d = len_clamped;
                        idx_d = '0;
                        // A zero-length vector is consumed without emitting anything.
                        if (len_clamped != '0) state_d = SEND;
                    end
                end
                SEND: begin
                    send_val  = 1'b1;
                    send_msg  = buf_q[idx_q[IW-2:0]];
                    send_last = is_last;
                    if (send_rdy) begin
                        if (is_last) state_d = IDLE;
                        else         idx_d   = idx_q + IW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule
